// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the MEM/WB stage: load opcodes and the canonical nop.
package mips_pkg;
  localparam logic [5:0]  OP_LB    = 6'h20;
  localparam logic [5:0]  OP_LH    = 6'h21;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_LBU   = 6'h24;
  localparam logic [5:0]  OP_LHU   = 6'h25;
  localparam logic [31:0] NOP_INST = 32'h0;
endpackage

// File: rtl/load_align.sv
// Combinational little-endian sub-word load alignment and extension.
// Optional MISALIGN_TRAP_EN adds a misaligned-access flag output.
module load_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{offset, 3'b000} +: 8];
    // Halves ignore offset[0]; a misaligned half reads as if it were aligned.
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
    case (opcode)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = raw;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = (((opcode == OP_LH) || (opcode == OP_LHU)) && offset[0]) ||
                    ((opcode == OP_LW) && (offset != 2'b00));
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, stall/flush and retired-instruction counter.
// Optional MISALIGN_TRAP_EN adds wb_misalign and suppresses writes of misaligned loads.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [DW-1:0]    mem_inst,
  input  logic [DW-1:0]    mem_alu_result,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_sel_dmem,
  input  logic             mem_wb_addr_sel,
  input  logic             mem_reg_write,
  output logic             wb_valid,
  output logic [DW-1:0]    wb_inst,
  output logic [DW-1:0]    alu_result,
  output logic [DW-1:0]    load_data,
  output logic             mux_sel_dmem,
  output logic             wb_addr_sel,
  output logic             wb_reg_write,
  output logic [CNT_W-1:0] instret
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             wb_misalign
`endif
);

  logic [31:0] aligned;
  logic        misalign;

`ifdef MISALIGN_TRAP_EN
  load_align u_align (
    .opcode   (mem_inst[31:26]),
    .offset   (mem_alu_result[1:0]),
    .raw      (mem_rdata),
    .data     (aligned),
    .misalign (misalign)
  );
`else
  load_align u_align (
    .opcode (mem_inst[31:26]),
    .offset (mem_alu_result[1:0]),
    .raw    (mem_rdata),
    .data   (aligned)
  );
  assign misalign = 1'b0;
`endif

  logic misalign_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_inst      <= NOP_INST;
      alu_result   <= '0;
      load_data    <= '0;
      mux_sel_dmem <= 1'b0;
      wb_addr_sel  <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_reg <= 1'b0;
      instret      <= '0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_inst      <= NOP_INST;
      alu_result   <= '0;
      load_data    <= '0;
      mux_sel_dmem <= 1'b0;
      wb_addr_sel  <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_reg <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_inst      <= mem_inst;
      alu_result   <= mem_alu_result;
      load_data    <= aligned;
      mux_sel_dmem <= mem_sel_dmem;
      wb_addr_sel  <= mem_wb_addr_sel;
      // Misaligned loads still retire but never touch the register file.
      wb_reg_write <= mem_reg_write & mem_valid & ~misalign;
      misalign_reg <= misalign & mem_valid;
      if (mem_valid) instret <= instret + CNT_W'(1);
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign wb_misalign = misalign_reg;
`endif

endmodule
